// File: rtl/rf_pkg.sv
// Shared types for the GPR writeback arbiter and its pending-write scoreboard.
// Optional round-robin arbitration is enabled with RF_ARB_RR_EN.
package rf_pkg;
   localparam int XLEN  = 64;
   localparam int NREG  = 32;
   localparam int CNT_W = 2;
   localparam int IDX_W = $clog2(NREG);

   typedef logic [IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_X0 = '0;

   typedef struct packed {
      logic            we;
      reg_idx_t        rd;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } wb_req_t;

   function automatic logic wb_writes(wb_req_t r);
      return r.we && (r.rd != REG_X0);
   endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request handshake: one instance per requester (EXU, LSU).
// master = requester, slave = arbiter.
interface rf_wb_arbiter_if;
   import rf_pkg::*;

   logic    valid;
   logic    ready;
   wb_req_t req;

   modport master (output valid, output req, input ready);
   modport slave  (input valid, input req, output ready);
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue increments, regfile write
// decrements; answers RAW busy queries and saturation stalls for decode.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     iss_valid,
   input  logic     iss_we,
   input  reg_idx_t iss_rd,
   output logic     iss_ready,
   input  reg_idx_t q_rs1,
   input  reg_idx_t q_rs2,
   output logic     q_rs1_busy,
   output logic     q_rs2_busy,
   input  logic     rf_we,
   input  reg_idx_t rf_waddr
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic             inc   [NREG];
   logic             dec   [NREG];
   logic             iss_inc;

   function automatic logic busy_of(reg_idx_t r);
      logic wr_now;
      wr_now = rf_we && (rf_waddr == r);
      // Regfile forwards a same-cycle write, so the last pending one is free.
      return (r != REG_X0) && (cnt_q[r] != '0) &&
             !((cnt_q[r] == CNT_ONE) && wr_now);
   endfunction

   always_comb begin
      iss_ready = !(iss_we && (iss_rd != REG_X0) &&
                    (cnt_q[iss_rd] == CNT_MAX)) ||
                  (rf_we && (rf_waddr == iss_rd));
      iss_inc   = iss_valid && iss_we && iss_ready &&
                  (iss_rd != REG_X0);
      q_rs1_busy = busy_of(q_rs1);
      q_rs2_busy = busy_of(q_rs2);
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         inc[i] = 1'b0;
         dec[i] = 1'b0;
         if (i != 0) begin
            inc[i] = iss_inc && (iss_rd == reg_idx_t'(i));
            dec[i] = rf_we && (rf_waddr == reg_idx_t'(i));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (inc[i] && !dec[i])
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            else if (dec[i] && !inc[i] && cnt_q[i] != '0)
               cnt_q[i] <= cnt_q[i] - CNT_ONE;
         end
      end
   end

   a_no_underflow: assert property (
      @(posedge clk) disable iff (rst)
      !(rf_we && (rf_waddr != REG_X0) && (cnt_q[rf_waddr] == '0))
   );
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester GPR write-port arbiter with registered write/commit stage.
// RF_ARB_RR_EN: round-robin on conflict; otherwise LSU has priority.
module rf_wb_arbiter
   import rf_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   rf_wb_arbiter_if.slave  exu,
   rf_wb_arbiter_if.slave  lsu,
   output logic            rf_we,
   output reg_idx_t        rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [XLEN-1:0] debug_wb_pc,
   output logic [31:0]     debug_wb_inst,
   input  logic            iss_valid,
   input  logic            iss_we,
   input  reg_idx_t        iss_rd,
   output logic            iss_ready,
   input  reg_idx_t        q_rs1,
   input  reg_idx_t        q_rs2,
   output logic            q_rs1_busy,
   output logic            q_rs2_busy
);
   logic    gnt_exu;
   logic    gnt_lsu;
   logic    gnt_any;
   wb_req_t sel;

`ifdef RF_ARB_RR_EN
   logic last_lsu_q;

   always_comb begin
      gnt_exu = exu.valid && (!lsu.valid || last_lsu_q);
      gnt_lsu = lsu.valid && (!exu.valid || !last_lsu_q);
   end

   // Reset leaves EXU as last-served, so the first conflict goes to LSU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_lsu_q <= 1'b0;
      else if (gnt_lsu)
         last_lsu_q <= 1'b1;
      else if (gnt_exu)
         last_lsu_q <= 1'b0;
   end
`else
   always_comb begin
      gnt_lsu = lsu.valid;
      gnt_exu = exu.valid && !lsu.valid;
   end
`endif

   assign exu.ready = gnt_exu;
   assign lsu.ready = gnt_lsu;
   assign gnt_any   = gnt_exu || gnt_lsu;

   always_comb begin
      sel = exu.req;
      unique case (1'b1)
         gnt_lsu: sel = lsu.req;
         gnt_exu: sel = exu.req;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we         <= 1'b0;
         rf_waddr      <= '0;
         rf_wdata      <= '0;
         debug_wb_pc   <= '0;
         debug_wb_inst <= '0;
      end else begin
         rf_we <= gnt_any && wb_writes(sel);
         if (gnt_any) begin
            rf_waddr      <= sel.rd;
            rf_wdata      <= sel.data;
            debug_wb_pc   <= sel.pc;
            debug_wb_inst <= sel.inst;
         end
      end
   end

   rf_scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_we     (iss_we),
      .iss_rd     (iss_rd),
      .iss_ready  (iss_ready),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .q_rs1_busy (q_rs1_busy),
      .q_rs2_busy (q_rs2_busy),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr)
   );
endmodule
